// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the dual-port memory responder.
package mem_resp_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int NBYTES = WORD_W / BYTE_W;
   localparam int LAT_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } port_state_t;

endpackage

// File: rtl/mem_resp_port.sv
// One request port: latency timer, latched request fields, array request/response sequencing.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; acceptance cycle (LAT=1 also tries the array here)
// WAIT   | latency timer running down
// ACCESS | asking for the array; stays here while the other port holds it
// RESP   | one-cycle response pulse, read data already registered
module mem_resp_port
   import mem_resp_pkg::*;
#(
   parameter int LAT       = 2,
   parameter int ADDR_BITS = 10,
   parameter bit WR_EN     = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rd,
   input  logic                 i_wr,
   input  logic [ADDR_BITS-1:0] i_idx,
   input  logic [NBYTES-1:0]    i_wmask,
   input  logic [WORD_W-1:0]    i_wdata,
   input  logic                 i_gnt,
   output logic                 o_arr_req,
   output logic                 o_arr_we,
   output logic [ADDR_BITS-1:0] o_arr_idx,
   output logic [NBYTES-1:0]    o_arr_wmask,
   output logic [WORD_W-1:0]    o_arr_wdata,
   output logic                 o_resp,
   output logic                 o_proto_err
);

   port_state_t          r_state;
   port_state_t          w_state_nxt;
   logic [LAT_W-1:0]     r_cnt;
   logic [LAT_W-1:0]     w_cnt_nxt;
   logic                 r_we;
   logic [ADDR_BITS-1:0] r_idx;
   logic [NBYTES-1:0]    r_wmask;
   logic [WORD_W-1:0]    r_wdata;

   logic w_wr;
   logic w_both;
   logic w_req;
   logic w_accept;

   assign w_wr     = WR_EN && i_wr;
   assign w_both   = i_rd && w_wr;
   assign w_req    = (i_rd || w_wr) && !w_both;
   assign w_accept = (r_state == IDLE) && w_req;

   // While IDLE the live request fields drive the array so LAT=1 can access in the acceptance cycle.
   assign o_arr_we    = (r_state == IDLE) ? w_wr    : r_we;
   assign o_arr_idx   = (r_state == IDLE) ? i_idx   : r_idx;
   assign o_arr_wmask = (r_state == IDLE) ? i_wmask : r_wmask;
   assign o_arr_wdata = (r_state == IDLE) ? i_wdata : r_wdata;
   assign o_resp      = (r_state == RESP);

   // State and latency timer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request fields are captured once at acceptance and held for the whole transaction.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we    <= w_wr;
         r_idx   <= i_idx;
         r_wmask <= i_wmask;
         r_wdata <= i_wdata;
      end
   end

   // Next-state, timer and array request.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_arr_req   = 1'b0;
      o_proto_err = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_both) begin
               o_proto_err = 1'b1;
            end else if (w_req) begin
               if (LAT == 1) begin
                  o_arr_req   = 1'b1;
                  w_state_nxt = i_gnt ? RESP : ACCESS;
               end else if (LAT == 2) begin
                  w_state_nxt = ACCESS;
               end else begin
                  // Timer counts the WAIT cycles still to go; ACCESS follows the cycle it reads 1.
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = LAT_W'((LAT > 2) ? (LAT - 2) : 1);
               end
            end
         end
         WAIT: begin
            if (r_cnt == LAT_W'(1)) begin
               w_state_nxt = ACCESS;
            end else begin
               w_cnt_nxt = r_cnt - LAT_W'(1);
            end
         end
         ACCESS: begin
            o_arr_req = 1'b1;
            if (i_gnt) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/dp_mem_responder.sv
// Instruction (A, read-only) and data (B, read/write) ports sharing one word array; B wins ties.
module dp_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int LAT_A     = 2,
   parameter int LAT_B     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_a,
   input  logic [31:0]       address_a,
   output logic              resp_a,
   output logic [WORD_W-1:0] rdata_a,
   input  logic              read_b,
   input  logic              write_b,
   input  logic [NBYTES-1:0] wmask_b,
   input  logic [31:0]       address_b,
   input  logic [WORD_W-1:0] wdata_b,
   output logic              resp_b,
   output logic [WORD_W-1:0] rdata_b,
   output logic              err
);

   logic [WORD_W-1:0]    r_mem [0:(2**ADDR_BITS)-1];
   logic [WORD_W-1:0]    r_rdata_a;
   logic [WORD_W-1:0]    r_rdata_b;
   logic                 r_err;

   logic                 w_req_a, w_req_b;
   logic                 w_gnt_a, w_gnt_b;
   logic                 w_we_a, w_we_b;
   logic [ADDR_BITS-1:0] w_idx_a, w_idx_b;
   logic [NBYTES-1:0]    w_wmask_a, w_wmask_b;
   logic [WORD_W-1:0]    w_wdata_a, w_wdata_b;
   logic                 w_resp_a, w_resp_b;
   logic                 w_perr_a, w_perr_b;
   logic                 w_unused_bits;

   // Address bits outside the word index are ignored, so addresses alias.
   assign w_unused_bits = ^{address_a[31:ADDR_BITS+2], address_a[1:0],
                            address_b[31:ADDR_BITS+2], address_b[1:0],
                            w_we_a, w_wmask_a, w_wdata_a};

   mem_resp_port #(.LAT(LAT_A), .ADDR_BITS(ADDR_BITS), .WR_EN(1'b0)) u_port_a (
      .clk         (clk),
      .rst         (rst),
      .i_rd        (read_a),
      .i_wr        (1'b0),
      .i_idx       (address_a[ADDR_BITS+1:2]),
      .i_wmask     ('0),
      .i_wdata     ('0),
      .i_gnt       (w_gnt_a),
      .o_arr_req   (w_req_a),
      .o_arr_we    (w_we_a),
      .o_arr_idx   (w_idx_a),
      .o_arr_wmask (w_wmask_a),
      .o_arr_wdata (w_wdata_a),
      .o_resp      (w_resp_a),
      .o_proto_err (w_perr_a)
   );

   mem_resp_port #(.LAT(LAT_B), .ADDR_BITS(ADDR_BITS), .WR_EN(1'b1)) u_port_b (
      .clk         (clk),
      .rst         (rst),
      .i_rd        (read_b),
      .i_wr        (write_b),
      .i_idx       (address_b[ADDR_BITS+1:2]),
      .i_wmask     (wmask_b),
      .i_wdata     (wdata_b),
      .i_gnt       (w_gnt_b),
      .o_arr_req   (w_req_b),
      .o_arr_we    (w_we_b),
      .o_arr_idx   (w_idx_b),
      .o_arr_wmask (w_wmask_b),
      .o_arr_wdata (w_wdata_b),
      .o_resp      (w_resp_b),
      .o_proto_err (w_perr_b)
   );

   // Grants are held off during reset so a transaction already in ACCESS never touches the array.
   assign w_gnt_b = w_req_b && !rst;
   assign w_gnt_a = w_req_a && !w_req_b && !rst;

   // Masked write from port B; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_gnt_b && w_we_b) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (w_wmask_b[i]) begin
               r_mem[w_idx_b][i*BYTE_W +: BYTE_W] <= w_wdata_b[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Synchronous reads into per-port data registers that hold between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         if (w_gnt_a) begin
            r_rdata_a <= r_mem[w_idx_a];
         end
         if (w_gnt_b && !w_we_b) begin
            r_rdata_b <= r_mem[w_idx_b];
         end
      end
   end

   // Sticky protocol error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_perr_a || w_perr_b) begin
         r_err <= 1'b1;
      end
   end

   assign resp_a  = w_resp_a;
   assign resp_b  = w_resp_b;
   assign rdata_a = r_rdata_a;
   assign rdata_b = r_rdata_b;
   assign err     = r_err;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: timeline reference model, per-cycle compare, directed and random traffic.
module tb_dp_mem_responder;

   localparam int LAT_A = 2;
   localparam int LAT_B = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read_a = 1'b0;
   logic [31:0] address_a = '0;
   logic        resp_a;
   logic [31:0] rdata_a;
   logic        read_b = 1'b0;
   logic        write_b = 1'b0;
   logic [3:0]  wmask_b = '0;
   logic [31:0] address_b = '0;
   logic [31:0] wdata_b = '0;
   logic        resp_b;
   logic [31:0] rdata_b;
   logic        err;

   dp_mem_responder #(.ADDR_BITS(10), .LAT_A(LAT_A), .LAT_B(LAT_B)) dut (
      .clk       (clk),
      .rst       (rst),
      .read_a    (read_a),
      .address_a (address_a),
      .resp_a    (resp_a),
      .rdata_a   (rdata_a),
      .read_b    (read_b),
      .write_b   (write_b),
      .wmask_b   (wmask_b),
      .address_b (address_b),
      .wdata_b   (wdata_b),
      .resp_b    (resp_b),
      .rdata_b   (rdata_b),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   logic [9:0] pool [8] = '{10'h040, 10'h080, 10'h0C0, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: got no response, expected one within bound (cycle %0d)", name, cyc);
   endtask

   // Reference model: each accepted request becomes eligible for the array LAT-1 cycles after
   // acceptance; the array serves B first, then A; response follows the serving cycle and the port
   // can accept again the cycle after the response.
   logic [31:0] mem_m [1024];
   bit          ma_busy = 0, mb_busy = 0;
   int          ma_elig, mb_elig, ma_free = 0, mb_free = 0;
   logic [9:0]  ma_idx, mb_idx;
   bit          mb_we;
   logic [3:0]  mb_mask;
   logic [31:0] mb_wdata;
   logic        exp_resp_a = 0, exp_resp_b = 0, exp_err = 0;
   logic [31:0] exp_rdata_a = 0, exp_rdata_b = 0;

   always @(posedge clk) begin : model
      bit sa;
      bit sb;
      sa = 0;
      sb = 0;
      if (rst) begin
         ma_busy = 0;
         mb_busy = 0;
         ma_free = cyc + 1;
         mb_free = cyc + 1;
         exp_rdata_a = 0;
         exp_rdata_b = 0;
         exp_err = 0;
         chk_en = 1'b1;
      end else begin
         if (!ma_busy && cyc >= ma_free && read_a) begin
            ma_busy = 1;
            ma_elig = cyc + LAT_A - 1;
            ma_idx  = address_a[11:2];
         end
         if (!mb_busy && cyc >= mb_free) begin
            if (read_b && write_b) begin
               exp_err = 1;
            end else if (read_b || write_b) begin
               mb_busy  = 1;
               mb_elig  = cyc + LAT_B - 1;
               mb_idx   = address_b[11:2];
               mb_we    = write_b;
               mb_mask  = wmask_b;
               mb_wdata = wdata_b;
            end
         end
         if (mb_busy && cyc >= mb_elig) begin
            sb = 1;
            if (mb_we) begin
               for (int i = 0; i < 4; i++)
                  if (mb_mask[i]) mem_m[mb_idx][i*8 +: 8] = mb_wdata[i*8 +: 8];
            end else begin
               exp_rdata_b = mem_m[mb_idx];
            end
            mb_busy = 0;
            mb_free = cyc + 2;
         end
         if (ma_busy && cyc >= ma_elig && !sb) begin
            sa = 1;
            exp_rdata_a = mem_m[ma_idx];
            ma_busy = 0;
            ma_free = cyc + 2;
         end
      end
      exp_resp_a = sa;
      exp_resp_b = sb;
      cyc++;
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("resp_a", {31'b0, resp_a}, {31'b0, exp_resp_a});
         chk("resp_b", {31'b0, resp_b}, {31'b0, exp_resp_b});
         chk("rdata_a", rdata_a, exp_rdata_a);
         chk("rdata_b", rdata_b, exp_rdata_b);
         chk("err", {31'b0, err}, {31'b0, exp_err});
      end
   end

   task automatic b_txn(input bit rd, input bit wr, input logic [31:0] ad, input logic [3:0] m,
                        input logic [31:0] d, output int lat, output logic [31:0] q);
      int t;
      int w;
      read_b = rd; write_b = wr; address_b = ad; wmask_b = m; wdata_b = d;
      t = cyc;
      w = 0;
      do begin @(negedge clk); w++; end while (!resp_b && w < 40);
      lat = cyc - t;
      q = rdata_b;
      if (!resp_b) timeout("b_txn");
      read_b = 0; write_b = 0;
   endtask

   task automatic a_txn(input logic [31:0] ad, output int lat, output logic [31:0] q);
      int t;
      int w;
      read_a = 1; address_a = ad;
      t = cyc;
      w = 0;
      do begin @(negedge clk); w++; end while (!resp_a && w < 40);
      lat = cyc - t;
      q = rdata_a;
      if (!resp_a) timeout("a_txn");
      read_a = 0;
   endtask

   initial begin : main
      int lat, t, ta, tb, nresp;
      logic [31:0] q, qa;

      repeat (3) @(negedge clk);
      rst = 0;
      repeat (20) @(negedge clk);
      chk("idle_resp_a", {31'b0, resp_a}, 32'd0);
      chk("idle_rdata_b", rdata_b, 32'd0);
      chk("idle_err", {31'b0, err}, 32'd0);

      // full write then read back on B
      @(negedge clk);
      b_txn(0, 1, 32'h100, 4'hF, 32'hDEADBEEF, lat, q);
      chk("wr_lat_b", lat, 3);
      @(negedge clk);
      b_txn(1, 0, 32'h100, 4'h0, 32'h0, lat, q);
      chk("rd_lat_b", lat, 3);
      chk("rd_data_b", q, 32'hDEADBEEF);
      chk("model_rd_b", exp_rdata_b, 32'hDEADBEEF);

      // partial write, A reads including aliases
      @(negedge clk);
      b_txn(0, 1, 32'h100, 4'b0010, 32'h0000AA00, lat, q);
      a_txn(32'h100, lat, q);
      chk("rd_lat_a", lat, 2);
      chk("partial_a", q, 32'hDEADAAEF);
      chk("model_partial_a", exp_rdata_a, 32'hDEADAAEF);
      @(negedge clk);
      a_txn(32'h1100, lat, q);
      chk("alias_a", q, 32'hDEADAAEF);
      a_txn(32'hABCD_E103, lat, q);
      chk("alias2_a", q, 32'hDEADAAEF);

      // zero mask write completes but changes nothing
      b_txn(0, 1, 32'h100, 4'h0, 32'h0, lat, q);
      chk("wmask0_lat", lat, 3);
      a_txn(32'h100, lat, q);
      chk("wmask0_data", q, 32'hDEADAAEF);

      // preload remaining pool words
      b_txn(0, 1, 32'h300, 4'hF, 32'h0BADF00D, lat, q);
      for (int i = 3; i < 8; i++) b_txn(0, 1, 32'(pool[i]) << 2, 4'hF, $urandom, lat, q);

      // contention: B accepted at t, A at t+1, both want the array at t+2, B wins
      @(negedge clk);
      t = cyc;
      write_b = 1; address_b = 32'h200; wdata_b = 32'h12345678; wmask_b = 4'hF;
      @(negedge clk);
      read_a = 1; address_a = 32'h200;
      ta = -1; tb = -1; qa = '0;
      for (int k = 0; k < 12 && (ta < 0 || tb < 0); k++) begin
         @(negedge clk);
         if (resp_b && tb < 0) begin tb = cyc; write_b = 0; end
         if (resp_a && ta < 0) begin ta = cyc; qa = rdata_a; read_a = 0; end
      end
      read_a = 0; write_b = 0;
      if (ta < 0 || tb < 0) timeout("contention");
      chk("cont_resp_b_cycle", tb - t, 3);
      chk("cont_resp_a_cycle", ta - t, 4);
      chk("cont_data_a", qa, 32'h12345678);

      // reset mid-transaction: A read dropped and retried, pending B write discarded
      @(negedge clk);
      t = cyc;
      read_a = 1; address_a = 32'h100;
      write_b = 1; address_b = 32'h300; wdata_b = 32'hFFFFFFFF; wmask_b = 4'hF;
      @(negedge clk);
      rst = 1; write_b = 0;
      @(negedge clk);
      rst = 0;
      ta = -1;
      for (int k = 0; k < 12 && ta < 0; k++) begin
         if (resp_a) ta = cyc;
         else @(negedge clk);
      end
      if (resp_a && ta < 0) ta = cyc;
      qa = rdata_a;
      read_a = 0;
      if (ta < 0) timeout("rst_retry");
      chk("rst_resp_a_cycle", ta - t, 4);
      chk("rst_data_a", qa, 32'hDEADAAEF);
      @(negedge clk);
      b_txn(1, 0, 32'h300, 4'h0, 32'h0, lat, q);
      chk("rst_write_dropped", q, 32'h0BADF00D);

      // random concurrent traffic on both ports
      @(negedge clk);
      fork
         begin : drv_a
            for (int i = 0; i < 60; i++) begin
               int wa;
               wa = 0;
               address_a = ($urandom & 32'hFFFF_F003) | (32'(pool[$urandom_range(0, 7)]) << 2);
               read_a = 1;
               do begin @(negedge clk); wa++; end while (!resp_a && wa < 40);
               if (!resp_a) timeout("rand_a");
               if ($urandom_range(0, 2) == 0) begin
                  read_a = 0;
                  repeat ($urandom_range(1, 3)) @(negedge clk);
               end
            end
            read_a = 0;
         end
         begin : drv_b
            for (int j = 0; j < 60; j++) begin
               int wb;
               bit wr;
               wb = 0;
               wr = $urandom_range(0, 1) == 1;
               address_b = ($urandom & 32'hFFFF_F003) | (32'(pool[$urandom_range(0, 7)]) << 2);
               wmask_b = 4'($urandom_range(0, 15));
               wdata_b = $urandom;
               read_b = !wr; write_b = wr;
               do begin @(negedge clk); wb++; end while (!resp_b && wb < 40);
               if (!resp_b) timeout("rand_b");
               if ($urandom_range(0, 2) == 0) begin
                  read_b = 0; write_b = 0;
                  repeat ($urandom_range(1, 3)) @(negedge clk);
               end
            end
            read_b = 0; write_b = 0;
         end
      join
      repeat (6) @(negedge clk);

      // protocol error: sticky, no response, cleared by reset
      read_b = 1; write_b = 1; address_b = 32'h100;
      chk("perr_before", {31'b0, err}, 32'd0);
      @(negedge clk);
      chk("perr_set", {31'b0, err}, 32'd1);
      nresp = 0;
      repeat (10) begin
         @(negedge clk);
         if (resp_b) nresp++;
      end
      chk("perr_no_resp", nresp, 0);
      read_b = 0; write_b = 0;
      repeat (3) @(negedge clk);
      chk("perr_sticky", {31'b0, err}, 32'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("perr_cleared", {31'b0, err}, 32'd0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
